// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events on din into HIGH_CYC-wide pulses separated by GAP_CYC low
// cycles, queueing overlapping events. Define RETRIGGER_EN to extend the pulse on din in HIGH.
module pulse_stretcher #(
    parameter int HIGH_CYC = 4,
    parameter int GAP_CYC  = 2,
    parameter int PEND_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(PEND_MAX+1)-1:0] pending,
    output logic                          overflow,
    output logic [1:0]                    state_dbg
);

    localparam int CMAX   = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int CNT_W  = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int PEND_W = $clog2(PEND_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_HIGH = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_GAP  = CNT_W'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [PEND_W-1:0] pending_next;
    logic              queue, consume, drop;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        queue      = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (din) begin
                    state_next = HIGH;
                    cnt_next   = CNT_HIGH;
                end
            end
            HIGH: begin
`ifdef RETRIGGER_EN
                if (din) begin
                    cnt_next = CNT_HIGH;
                end else if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    state_next = GAP;
                    cnt_next   = CNT_GAP;
                end
`else
                queue = din;
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    state_next = GAP;
                    cnt_next   = CNT_GAP;
                end
`endif
            end
            GAP: begin
                queue = din;
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (pending != '0 || din) begin
                    // A din in the last gap cycle with nothing queued is queued and
                    // consumed at once, so pending is left untouched.
                    state_next = HIGH;
                    cnt_next   = CNT_HIGH;
                    consume    = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pending_next = pending;
        drop         = 1'b0;
        if (queue && !consume) begin
            if (pending == PEND_TOP) begin
                drop = 1'b1;
            end else begin
                pending_next = pending + PEND_W'(1);
            end
        end else if (consume && !queue) begin
            pending_next = pending - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= '0;
            dout     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            pending  <= pending_next;
            dout     <= (state_next == HIGH);
            busy     <= (state_next != IDLE);
            overflow <= drop;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: per-cycle checks of dout/busy/pending/overflow
// against hand-written cycle vectors (bit i = cycle i; reset held for cycles 0-4).
module tb_pulse_stretcher;

    logic       clk;
    logic       reset;
    logic       din;
    logic       dout;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;
    logic [1:0] state_dbg;

    int n_checks;
    int n_fail;

    pulse_stretcher #(
        .HIGH_CYC(4),
        .GAP_CYC (2),
        .PEND_MAX(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] rng(input int lo, input int hi);
        logic [47:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Inputs for cycle c are applied 1 time unit after posedge c; the outputs seen then
    // are the registered response to cycle c-1.
    task automatic run_test(input string name, input logic [47:0] dv, input logic [47:0] rv,
                            input logic [47:0] de, input logic [47:0] be,
                            input logic [47:0] pl, input logic [47:0] ph,
                            input logic [47:0] oe);
        for (int c = 0; c < 48; c++) begin
            @(posedge clk);
            #1;
            din   = dv[c];
            reset = (c < 5) || rv[c];
            if (c >= 1) begin
                n_checks++;
                assert (dout === de[c]) else begin
                    n_fail++;
                    $error("FAIL %s dout cycle %0d: observed %b expected %b", name, c, dout, de[c]);
                end
                n_checks++;
                assert (busy === be[c]) else begin
                    n_fail++;
                    $error("FAIL %s busy cycle %0d: observed %b expected %b", name, c, busy, be[c]);
                end
                n_checks++;
                assert (pending === {ph[c], pl[c]}) else begin
                    n_fail++;
                    $error("FAIL %s pending cycle %0d: observed %0d expected %0d", name, c,
                           pending, {ph[c], pl[c]});
                end
                n_checks++;
                assert (overflow === oe[c]) else begin
                    n_fail++;
                    $error("FAIL %s overflow cycle %0d: observed %b expected %b", name, c,
                           overflow, oe[c]);
                end
                if (!be[c]) begin
                    n_checks++;
                    assert (state_dbg === 2'd0) else begin
                        n_fail++;
                        $error("FAIL %s state cycle %0d: observed %0d expected 0", name, c,
                               state_dbg);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [47:0] z;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        din      = 1'b0;
        z        = '0;

        // Single event.
        run_test("single", rng(10, 10), z, rng(11, 14), rng(11, 16), z, z, z);

`ifdef RETRIGGER_EN
        run_test("two_ev", rng(10, 10) | rng(12, 12), z, rng(11, 16), rng(11, 18), z, z, z);
        run_test("burst", rng(10, 15), z, rng(11, 19), rng(11, 21), z, z, z);
        run_test("retrig", rng(10, 10) | rng(13, 13), z, rng(11, 17), rng(11, 19), z, z, z);
        run_test("gap_q", rng(10, 11) | rng(16, 16), z, rng(11, 15) | rng(18, 21),
                 rng(11, 23), rng(17, 17), z, z);
`else
        run_test("two_ev", rng(10, 10) | rng(12, 12), z, rng(11, 14) | rng(17, 20),
                 rng(11, 22), rng(13, 16), z, z);
        // Saturating burst: events at 14 and 15 dropped.
        run_test("burst", rng(10, 15), z,
                 rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32), rng(11, 34),
                 rng(12, 12) | rng(14, 16) | rng(23, 28), rng(13, 22), rng(15, 16));
        run_test("retrig", rng(10, 10) | rng(13, 13), z, rng(11, 14) | rng(17, 20),
                 rng(11, 22), rng(14, 16), z, z);
        // Queue and consume in the same final gap cycle keeps pending at 1.
        run_test("gap_q", rng(10, 11) | rng(16, 16), z, rng(11, 14) | rng(17, 20) | rng(23, 26),
                 rng(11, 28), rng(12, 22), z, z);
`endif

        // Mid-pulse reset with din asserted in the reset cycle.
        run_test("reset_mid", rng(10, 10) | rng(12, 12), rng(12, 12), rng(11, 12), rng(11, 12),
                 z, z, z);
        // Event in the final gap cycle is consumed directly.
        run_test("last_gap", rng(10, 10) | rng(16, 16), z, rng(11, 14) | rng(17, 20),
                 rng(11, 22), z, z, z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
